sprite_bitmap_loader: RTL

- Write-side counterpart to the sprite renderers: accepts a 1-bpp sprite bitmap as a byte stream and assembles it into ROWS x COLS row words.
- Double-buffered. Loads go into a back buffer; the buffers swap only at a frame boundary, so a renderer reading the front buffer never sees a half-written sprite.
- Sits between a byte source (UART or ROM sequencer) and a sprite renderer's row lookup.

---
 rtl/sprite_bitmap_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sprite_bitmap_loader.sv
// Double-buffered 1-bpp sprite loader: assembles a byte stream into ROWS x COLS row words.
// Optional feature macro SPRITE_LOADER_MIRROR_EN adds mirror_in (horizontal flip of a whole load).
module sprite_bitmap_loader #(
    parameter int ROWS = 16,
    parameter int COLS = 16
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            start_in,
    input  logic [7:0]      byte_in,
    input  logic            byte_valid_in,
    output logic            byte_ready_out,
    input  logic            frame_start_in,
    input  logic [3:0]      row_addr_in,
    output logic [COLS-1:0] row_data_out,
    output logic            load_busy_out,
    output logic            load_done_out,
    output logic            swap_out
`ifdef SPRITE_LOADER_MIRROR_EN
    ,
    input  logic            mirror_in
`endif
);

    localparam int BPR = COLS / 8;
    localparam int AW  = $clog2(ROWS);
    localparam int BW  = (BPR > 1) ? $clog2(BPR) : 1;
    localparam logic [BW-1:0] BYTE_LAST = BW'(BPR - 1);
    localparam logic [AW-1:0] ROW_LAST  = AW'(ROWS - 1);
    localparam logic [4:0]    ROWS_LIM  = 5'(ROWS);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PENDING} state_t;

    state_t          state_reg, state_next;
    logic [BW-1:0]   byte_cnt_reg;
    logic [AW-1:0]   row_cnt_reg;
    logic            front_sel_reg;
    logic            ready_reg, done_reg, swap_reg;
    logic [COLS-1:0] row_data_reg;
    logic [COLS-1:0] buf0 [0:ROWS-1];
    logic [COLS-1:0] buf1 [0:ROWS-1];
    logic [COLS-1:0] row_word, row_wr;
    logic [AW-1:0]   rd_idx;
    logic            accept, row_end, last_byte, swap_now;

    // start_in wins over everything, including a byte offered in the same cycle
    assign accept    = (state_reg == ST_LOAD) && byte_valid_in && !start_in;
    assign row_end   = accept && (byte_cnt_reg == BYTE_LAST);
    assign last_byte = row_end && (row_cnt_reg == ROW_LAST);
    assign swap_now  = (state_reg == ST_PENDING) && frame_start_in && !start_in;
    assign rd_idx    = row_addr_in[AW-1:0];

    generate
        if (COLS > 8) begin : g_shift
            logic [COLS-9:0] shift_reg;
            assign row_word = {shift_reg, byte_in};
            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in)
                    shift_reg <= '0;
                else if (accept)
                    shift_reg <= row_word[COLS-9:0];
            end
        end else begin : g_noshift
            assign row_word = byte_in;
        end
    endgenerate

`ifdef SPRITE_LOADER_MIRROR_EN
    logic            mirror_reg;
    logic [COLS-1:0] row_mirror;
    for (genvar gi = 0; gi < COLS; gi++) begin : g_rev
        assign row_mirror[gi] = row_word[COLS-1-gi];
    end
    assign row_wr = mirror_reg ? row_mirror : row_word;
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            mirror_reg <= 1'b0;
        else if (start_in)
            mirror_reg <= mirror_in;
    end
`else
    assign row_wr = row_word;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    state_next = ST_IDLE;
            ST_LOAD:    if (last_byte) state_next = ST_PENDING;
            ST_PENDING: if (frame_start_in) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
        if (start_in)
            state_next = ST_LOAD;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg     <= ST_IDLE;
            byte_cnt_reg  <= '0;
            row_cnt_reg   <= '0;
            front_sel_reg <= 1'b0;
            ready_reg     <= 1'b0;
            done_reg      <= 1'b0;
            swap_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == ST_LOAD);
            done_reg  <= last_byte;
            swap_reg  <= swap_now;
            if (swap_now)
                front_sel_reg <= ~front_sel_reg;
            if (start_in) begin
                byte_cnt_reg <= '0;
                row_cnt_reg  <= '0;
            end else if (accept) begin
                if (row_end) begin
                    byte_cnt_reg <= '0;
                    row_cnt_reg  <= row_cnt_reg + 1'b1;
                end else begin
                    byte_cnt_reg <= byte_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Completed rows always go to whichever buffer is not currently in front
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < ROWS; i++) begin
                buf0[i] <= '0;
                buf1[i] <= '0;
            end
        end else if (row_end) begin
            if (front_sel_reg)
                buf0[row_cnt_reg] <= row_wr;
            else
                buf1[row_cnt_reg] <= row_wr;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            row_data_reg <= '0;
        else if ({1'b0, row_addr_in} < ROWS_LIM)
            row_data_reg <= front_sel_reg ? buf1[rd_idx] : buf0[rd_idx];
        else
            row_data_reg <= '0;
    end

    assign byte_ready_out = ready_reg;
    assign row_data_out   = row_data_reg;
    assign load_busy_out  = (state_reg != ST_IDLE);
    assign load_done_out  = done_reg;
    assign swap_out       = swap_reg;

endmodule
